// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Shares one SRAM-like bus (req / addr_ok / data_ok) between the instruction
// fetch port and the EX/ME data port. A grant is held until the address
// handshake completes, the requester of every accepted transaction is queued
// in an in-order tag FIFO, and each returned response is routed to the
// requester at the head of that FIFO.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   inst_*                fetch request (req/addr) and response (addr_ok/data_ok/rdata)
//   data_*                load/store request (req/wr/size/wstrb/addr/wdata) and response
//   bus_*                 shared memory bus towards the AXI bridge
//   err_unexpected        sticky flag: a bus response arrived with no transaction outstanding
module sram_bus_arbiter #(
  parameter int OUTST_DEPTH  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        err_unexpected
);

  localparam int PTR_W = $clog2(OUTST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(OUTST_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX    = SC_W'(STARVE_LIMIT);

  typedef enum logic {
    FREE,
    LOCKED
  } arb_state_t;

  arb_state_t       state;
  logic             lock_id;
  logic [SC_W-1:0]  starve_cnt;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             tag_mem [OUTST_DEPTH];

  logic win_valid;
  logic win_id;
  logic fifo_full;
  logic push;
  logic pop;
  logic head_id;

  // Pick the requester for this cycle. While locked only the locked requester
  // is considered; otherwise data has priority unless inst has been passed
  // over STARVE_LIMIT times in a row, in which case inst is forced through.
  always_comb begin
    win_valid = 1'b0;
    win_id    = 1'b0;
    if (state == LOCKED) begin
      win_id    = lock_id;
      win_valid = lock_id ? data_req : inst_req;
    end else if (data_req && !(inst_req && starve_cnt == STARVE_MAX)) begin
      win_valid = 1'b1;
      win_id    = 1'b1;
    end else if (inst_req) begin
      win_valid = 1'b1;
      win_id    = 1'b0;
    end
  end

  // A full FIFO blocks new requests even if a response frees a slot this
  // same cycle, which keeps bus_req off the response path.
  assign fifo_full = (fifo_count == FIFO_FULL_CNT);
  assign bus_req   = win_valid & ~fifo_full;
  assign push      = bus_req & bus_addr_ok;
  assign pop       = bus_data_ok & (fifo_count != '0);
  assign head_id   = tag_mem[rd_ptr];

  // Request fields follow the winner; fetches are always word reads.
  always_comb begin
    if (win_id) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else begin
      bus_wr    = 1'b0;
      bus_size  = 2'd2;
      bus_wstrb = 4'b0000;
      bus_addr  = inst_addr;
      bus_wdata = 32'h0;
    end
  end

  assign inst_addr_ok = push & ~win_id;
  assign data_addr_ok = push & win_id;
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  // Arbiter lock: a request that is presented but not accepted keeps the
  // grant until the bus takes the address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FREE;
      lock_id <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (bus_req && !bus_addr_ok) begin
            state   <= LOCKED;
            lock_id <= win_id;
          end
        end
        LOCKED: begin
          if (push) begin
            state <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  // Starvation counter: counts data acceptances that happen while a fetch is
  // waiting, and restarts whenever the fetch gets in or stops asking.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      starve_cnt <= '0;
    end else if (data_addr_ok && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  // Tag FIFO pointers and occupancy. Power-of-two depth lets the pointers
  // wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= win_id;
    end
  end

  // Sticky error for a response with nothing outstanding; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_unexpected <= 1'b0;
    end else if (bus_data_ok && fifo_count == '0) begin
      err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter
// Directed self-checking bench for sram_bus_arbiter with default parameters
// (OUTST_DEPTH = 4, STARVE_LIMIT = 4). Inputs change 2 time units after the
// rising edge and outputs are sampled 1 unit later, well away from the edge.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        err_unexpected;

  int n_assert = 0;
  int n_fail   = 0;

  sram_bus_arbiter #(
    .OUTST_DEPTH (4),
    .STARVE_LIMIT(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_wstrb    (data_wstrb),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .bus_req       (bus_req),
    .bus_wr        (bus_wr),
    .bus_size      (bus_size),
    .bus_wstrb     (bus_wstrb),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_addr_ok   (bus_addr_ok),
    .bus_data_ok   (bus_data_ok),
    .bus_rdata     (bus_rdata),
    .err_unexpected(err_unexpected)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Advance to 2 units after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  // Drive the request/handshake inputs for this cycle and let them settle.
  task automatic applyStimulus(input logic ireq, input logic dreq,
                               input logic baok, input logic bdok,
                               input logic [31:0] brdata);
    inst_req    = ireq;
    data_req    = dreq;
    bus_addr_ok = baok;
    bus_data_ok = bdok;
    bus_rdata   = brdata;
    #1;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] starve_seq;
    starve_seq  = 10'b0111101111;   // bit i = 1 when data wins cycle i

    reset       = 1'b1;
    inst_req    = 1'b0;
    inst_addr   = 32'h1C00_0000;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;

    // Reset state
    cycle();
    cycle();
    #1;
    checkOutput("reset bus_req", bus_req, 0);
    checkOutput("reset inst_addr_ok", inst_addr_ok, 0);
    checkOutput("reset data_addr_ok", data_addr_ok, 0);
    checkOutput("reset err_unexpected", err_unexpected, 0);
    reset = 1'b0;
    cycle();
    checkOutput("post-reset bus_req", bus_req, 0);

    // Single fetch, response two cycles later
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("t1 bus_req", bus_req, 1);
    checkOutput("t1 bus_addr", bus_addr, 32'h1C00_0000);
    checkOutput("t1 bus_size", bus_size, 2);
    checkOutput("t1 bus_wr", bus_wr, 0);
    checkOutput("t1 inst_addr_ok", inst_addr_ok, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("t1 c1 inst_data_ok", inst_data_ok, 0);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'h0280_0C0C);
    checkOutput("t1 inst_data_ok", inst_data_ok, 1);
    checkOutput("t1 inst_rdata", inst_rdata, 32'h0280_0C0C);
    checkOutput("t1 data_data_ok", data_data_ok, 0);
    cycle();

    // Simultaneous fetch and load: data first, then inst; responses in order
    data_addr = 32'h0000_8000;
    data_size = 2'd2;
    data_wr   = 1'b0;
    applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("t2 data_addr_ok", data_addr_ok, 1);
    checkOutput("t2 inst_addr_ok c0", inst_addr_ok, 0);
    checkOutput("t2 bus_addr c0", bus_addr, 32'h0000_8000);
    cycle();
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("t2 inst_addr_ok c1", inst_addr_ok, 1);
    checkOutput("t2 bus_addr c1", bus_addr, 32'h1C00_0000);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'hAAAA_0001);
    checkOutput("t2 resp A data_data_ok", data_data_ok, 1);
    checkOutput("t2 resp A inst_data_ok", inst_data_ok, 0);
    checkOutput("t2 resp A data_rdata", data_rdata, 32'hAAAA_0001);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'hBBBB_0002);
    checkOutput("t2 resp B inst_data_ok", inst_data_ok, 1);
    checkOutput("t2 resp B data_data_ok", data_data_ok, 0);
    cycle();

    // Store held off by the bus for 3 cycles; inst rises during the lock
    data_addr  = 32'h0000_9000;
    data_wr    = 1'b1;
    data_wstrb = 4'hF;
    data_wdata = 32'h1234_5678;
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("t3 bus_req", bus_req, 1);
    checkOutput("t3 data_addr_ok", data_addr_ok, 0);
    cycle();
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("t3 c1 bus_addr", bus_addr, 32'h0000_9000);
    cycle();
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkOutput("t3 locked bus_addr", bus_addr, 32'h0000_9000);
    checkOutput("t3 locked bus_wr", bus_wr, 1);
    checkOutput("t3 locked bus_wdata", bus_wdata, 32'h1234_5678);
    checkOutput("t3 locked inst_addr_ok", inst_addr_ok, 0);
    cycle();
    applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("t3 accept data_addr_ok", data_addr_ok, 1);
    checkOutput("t3 accept inst_addr_ok", inst_addr_ok, 0);
    checkOutput("t3 accept bus_wstrb", bus_wstrb, 4'hF);
    cycle();
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("t3 next inst_addr_ok", inst_addr_ok, 1);
    checkOutput("t3 next bus_addr", bus_addr, 32'h1C00_0000);
    checkOutput("t3 next bus_wstrb", bus_wstrb, 4'h0);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'hC0DE_0003);
    checkOutput("t3 drain data_data_ok", data_data_ok, 1);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'hC0DE_0004);
    checkOutput("t3 drain inst_data_ok", inst_data_ok, 1);
    cycle();

    // Both requests held: starvation limit forces inst every fifth grant
    data_addr = 32'h0000_8000;
    data_wr   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 1, (i > 0), 32'h5000_0000 + i);
      checkOutput("t4 data_addr_ok", data_addr_ok, starve_seq[i]);
      checkOutput("t4 inst_addr_ok", inst_addr_ok, !starve_seq[i]);
      if (i > 0) begin
        checkOutput("t4 data_data_ok", data_data_ok, starve_seq[i-1]);
      end
      cycle();
    end
    applyStimulus(0, 0, 0, 1, 32'h0);
    checkOutput("t4 last inst_data_ok", inst_data_ok, 1);
    cycle();

    // Fill the FIFO with D,D,I,I; full blocks bus_req even with a pop
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("t5 push0", data_addr_ok, 1);
    cycle();
    applyStimulus(0, 1, 1, 0, 32'h0);
    checkOutput("t5 push1", data_addr_ok, 1);
    cycle();
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("t5 push2", inst_addr_ok, 1);
    cycle();
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("t5 push3", inst_addr_ok, 1);
    cycle();
    applyStimulus(1, 0, 1, 1, 32'hD000_0001);
    checkOutput("t5 full bus_req", bus_req, 0);
    checkOutput("t5 full inst_addr_ok", inst_addr_ok, 0);
    checkOutput("t5 full pop data_data_ok", data_data_ok, 1);
    cycle();
    applyStimulus(1, 0, 1, 0, 32'h0);
    checkOutput("t5 reassert bus_req", bus_req, 1);
    checkOutput("t5 reassert inst_addr_ok", inst_addr_ok, 1);
    cycle();
    applyStimulus(0, 0, 0, 1, 32'hD000_0002);
    checkOutput("t5 order 1 data", data_data_ok, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'hE000_0000 + i);
      checkOutput("t5 order inst", inst_data_ok, 1);
      checkOutput("t5 order no data", data_data_ok, 0);
      cycle();
    end

    // Response with empty FIFO
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("t6 inst_data_ok", inst_data_ok, 0);
    checkOutput("t6 data_data_ok", data_data_ok, 0);
    checkOutput("t6 err same cycle", err_unexpected, 0);
    cycle();
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("t6 err next cycle", err_unexpected, 1);
    cycle();
    checkOutput("t6 err sticky", err_unexpected, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    checkOutput("t6 err after reset", err_unexpected, 0);
    checkOutput("t6 bus_req after reset", bus_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
